// File: rtl/accbuf_stack_if.sv
// Request/response bundle for the LIFO accumulator buffer.
// The datapath acts as master and the buffer as slave.
interface accbuf_stack_if #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4
);
  localparam int CNT_W = $clog2(DEPTH + 1);

  logic [WIDTH-1:0] write_data_accbuf;
  logic             push;
  logic             pop;
  logic             clr_err;
  logic [WIDTH-1:0] read_data_accbuf;
  logic [CNT_W-1:0] count;
  logic             empty;
  logic             full;
  logic             overflow;
  logic             underflow;

  modport master (
    output write_data_accbuf, push, pop, clr_err,
    input  read_data_accbuf, count, empty, full, overflow, underflow
  );

  modport slave (
    input  write_data_accbuf, push, pop, clr_err,
    output read_data_accbuf, count, empty, full, overflow, underflow
  );
endinterface

// File: rtl/accbuf_stack.sv
// LIFO accumulator buffer: a circular buffer indexed by a head pointer that marks
// the top entry, with a registered top-of-stack, occupancy flags and sticky errors.
module accbuf_stack #(
  parameter int WIDTH     = 8,
  parameter int DEPTH     = 4,
  parameter bit OVERWRITE = 1'b0
) (
  input  logic          CLK,
  input  logic          RST,
  accbuf_stack_if.slave bus
);
  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = $clog2(DEPTH + 1);

  typedef enum logic [2:0] {
    OP_IDLE, OP_PUSH, OP_DROP, OP_WRAP, OP_POP, OP_POP_LAST, OP_UNDER, OP_REPLACE
  } op_e;

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PTR_W-1:0] head, head_up, head_dn;
  logic [CNT_W-1:0] cnt;
  logic [WIDTH-1:0] rd;
  logic             empty_q, full_q, ovf_q, unf_q;
  op_e              op;

  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
    return (p == PTR_W'(DEPTH - 1)) ? '0 : p + PTR_W'(1);
  endfunction

  function automatic logic [PTR_W-1:0] ptr_dec(input logic [PTR_W-1:0] p);
    return (p == '0) ? PTR_W'(DEPTH - 1) : p - PTR_W'(1);
  endfunction

  assign head_up = ptr_inc(head);
  assign head_dn = ptr_dec(head);

  // A simultaneous push+pop on a non-empty stack is a top replacement; on an
  // empty stack it degrades to a plain push.
  always_comb begin
    op = OP_IDLE;
    if (bus.push && bus.pop && !empty_q)
      op = OP_REPLACE;
    else if (bus.push)
      op = !full_q ? OP_PUSH : (OVERWRITE ? OP_WRAP : OP_DROP);
    else if (bus.pop)
      op = empty_q ? OP_UNDER : ((cnt == CNT_W'(1)) ? OP_POP_LAST : OP_POP);
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      head    <= '0;
      cnt     <= '0;
      rd      <= '0;
      empty_q <= 1'b1;
      full_q  <= 1'b0;
      ovf_q   <= 1'b0;
      unf_q   <= 1'b0;
    end else begin
      case (op)
        OP_PUSH: begin
          head    <= head_up;
          cnt     <= cnt + CNT_W'(1);
          rd      <= bus.write_data_accbuf;
          empty_q <= 1'b0;
          full_q  <= (cnt == CNT_W'(DEPTH - 1));
        end
        // When full, head_up already points at the oldest slot, so advancing
        // the head overwrites the bottom entry with no data movement.
        OP_WRAP: begin
          head <= head_up;
          rd   <= bus.write_data_accbuf;
        end
        OP_POP: begin
          head   <= head_dn;
          cnt    <= cnt - CNT_W'(1);
          rd     <= mem[head_dn];
          full_q <= 1'b0;
        end
        OP_POP_LAST: begin
          head    <= head_dn;
          cnt     <= '0;
          rd      <= '0;
          empty_q <= 1'b1;
          full_q  <= 1'b0;
        end
        OP_REPLACE: rd <= bus.write_data_accbuf;
        default: ;
      endcase
      // Setting beats clearing when both happen in the same cycle.
      ovf_q <= (ovf_q && !bus.clr_err) || (op == OP_DROP) || (op == OP_WRAP);
      unf_q <= (unf_q && !bus.clr_err) || (op == OP_UNDER);
    end
  end

  // NOTE: storage is deliberately left out of reset; count and head define
  // which entries are valid, so clearing the array would only cost reset fan-out.
  always_ff @(posedge CLK) begin
    if (!RST) begin
      case (op)
        OP_PUSH, OP_WRAP: mem[head_up] <= bus.write_data_accbuf;
        OP_REPLACE:       mem[head]    <= bus.write_data_accbuf;
        default: ;
      endcase
    end
  end

  assign bus.read_data_accbuf = rd;
  assign bus.count            = cnt;
  assign bus.empty            = empty_q;
  assign bus.full             = full_q;
  assign bus.overflow         = ovf_q;
  assign bus.underflow        = unf_q;
endmodule

// File: doc/accbuf_stack.md
# accbuf_stack

Parametrised LIFO accumulator buffer, successor to the single-entry accumulator buffer. Holds up to DEPTH signed accumulator snapshots of WIDTH bits, with write-through on push, pop-to-restore, occupancy flags and sticky error flags. Sits beside the accumulator: the datapath pushes $acc before nested operations and pops to restore it.

## Interface

- WIDTH, 8, data width in bits (≥2); data is signed two's complement, stored and returned bit-exact.
- DEPTH, 4, number of entries (≥2).
- OVERWRITE, 0, full-push policy: 0 = drop the new value; 1 = discard the oldest entry and accept the new value.
- CLK  input  1  clock; all state changes on the rising edge.
- RST  input  1  reset, synchronous, active-high.
- write_data_accbuf  input  WIDTH  value to push.
- push  input  1  push request, sampled at the edge.
- pop  input  1  pop request, sampled at the edge.
- clr_err  input  1  clears the sticky error flags.
- read_data_accbuf  output  WIDTH  registered top-of-stack; 0 when empty.
- count  output  $clog2(DEPTH+1)  occupied entries, 0..DEPTH.
- empty  output  1  count == 0.
- full  output  1  count == DEPTH.
- overflow  output  1  sticky; push attempted while full.
- underflow  output  1  sticky; pop attempted while empty.

## Operation

- Reset (RST=1 at an edge): count=0, empty=1, full=0, read_data_accbuf=0, overflow=0, underflow=0. Storage contents need not be cleared. RST overrides push, pop and clr_err in the same cycle.
- Idle (push=0, pop=0): no state change; read_data_accbuf holds.
- Push only, not full: store the value on top and increment count. read_data_accbuf takes write_data_accbuf at the same edge (write-through).
- Push only, full, OVERWRITE=0: storage, count and read_data are unchanged; overflow is set.
- Push only, full, OVERWRITE=1: the bottom (oldest) entry is discarded and the new value becomes top. count stays DEPTH, read_data takes the new value, and overflow is set. Implement as a circular buffer with head pointer wrap-around, not a physical shift.
- Pop only, count ≥ 2: count decrements and read_data shows the entry below the old top.
- Pop only, count = 1: count goes to 0 and read_data goes to 0.
- Pop only, empty: no state change; read_data stays 0; underflow is set.
- Push and pop together, not empty: replace the top with write_data. count is unchanged; read_data takes write_data; no flags change, even when full.
- Push and pop together, empty: treated as a push (count goes to 1); underflow is not set.
- clr_err=1 clears overflow and underflow. If a new error event occurs in the same cycle, setting wins and the flag stays 1.
- full and empty are derived registers and are never asserted together.

## Timing

- Single clock domain; every output is a registered flop output with no combinational input-to-output path.
- Latency is one edge. The effect of a request sampled at edge N is visible on all outputs after edge N.
- Back-to-back push/pop is allowed every cycle; there is no ready/stall handshake. Requests that cannot be honoured are dropped and flagged as described above.
- Pointer arithmetic is modulo DEPTH. count saturates at 0 and DEPTH and never wraps.
- RST mid-sequence takes effect at the next edge regardless of pending requests. The push or pop in that cycle is discarded.

## Test plan

- Values WIDTH=8, DEPTH=4, OVERWRITE=0 unless stated.
- Reset, then push 0x11, 0x22, 0x80 on consecutive cycles: read_data 0x11, 0x22, 0x80 (signed −128, bit-exact), count 3. Then pop: read_data 0x22, count 2, empty 0.
- Fill with 0x11, 0x22, 0x33, 0x44, then push 0x55: full=1, overflow=1, read_data 0x44, count 4. Four pops give read_data 0x33, 0x22, 0x11, 0x00, ending with empty=1.
- OVERWRITE=1, push 0x01..0x05: read_data 0x05, count 4, overflow=1. Four pops give 0x04, 0x03, 0x02, 0x00; 0x01 is lost; empty=1.
- Pop while empty: underflow=1, read_data 0x00, count 0. Then clr_err alone clears underflow to 0. Then clr_err together with a pop on empty leaves underflow=1.
- With stack 0x11, 0x22, push+pop with 0x99: read_data 0x99, count 2. Then pop gives 0x11. On an empty stack, push+pop with 0x77 gives count 1, read_data 0x77, underflow 0.
- With 3 entries, assert RST while push=1 carries 0x66: after the edge count 0, empty 1, full 0, read_data 0x00, flags 0. The following push of 0x12 gives read_data 0x12, count 1.
